// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg -- shared encodings for the memory pipeline stage.
//   Holds the write-address/write-data select codes, access-size codes,
//   the FSM state codes, the stage-register layout and small decode helpers.
package mem_stage_pkg;

    // Write-address select (cregwa)
    localparam logic       CWA_RT   = 1'b0;
    localparam logic       CWA_RD   = 1'b1;

    // Write-data select (cregwd)
    localparam logic [1:0] CWD_ALU  = 2'b00;
    localparam logic [1:0] CWD_MEM  = 2'b01;

    // Access size (memlen); 2'b11 is unused and handled like a word
    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef struct packed {
        logic        cregwa;
        logic [1:0]  cregwd;
        logic        regwe;
        logic [1:0]  memlen;
        logic        memwe;
        logic        memsign;
        logic [31:0] rd2;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] aluout;
    } stage_t;

    // A store wins over the load encoding if both are set.
    function automatic logic is_access(input logic memwe, input logic [1:0] cregwd);
        return memwe | (cregwd == CWD_MEM);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] memlen, input logic [1:0] a);
        logic mis;
        case (memlen)
            LEN_BYTE: mis = 1'b0;
            LEN_HALF: mis = a[0];
            default:  mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory bus between the memory stage and the data memory.
//   dmem_req   request, held until dmem_ack
//   dmem_we    write
//   dmem_addr  word address, bits[1:0] always 0
//   dmem_be    byte enables
//   dmem_wdata lane-aligned store data
//   dmem_ack   completion
//   dmem_rdata read word
// master: the memory stage; slave: the data memory.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_align.sv
// mem_align -- combinational byte-lane logic for the memory stage.
//   memlen   access size
//   memsign  sign-extend loads
//   addr_lo  byte offset within the word
//   st_data  store data from the register file
//   ld_word  raw read word from memory
//   be       byte enables
//   wdata    store data replicated onto every lane
//   ld_data  selected load lane shifted to bit 0 and extended
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  memlen,
    input  logic        memsign,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (memlen)
            LEN_BYTE: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            LEN_HALF: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = ld_word[7:0];
        case (addr_lo)
            2'd0: ld_byte = ld_word[7:0];
            2'd1: ld_byte = ld_word[15:8];
            2'd2: ld_byte = ld_word[23:16];
            2'd3: ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        // Halves are only ever aligned here; misaligned ones never reach memory.
        ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];

        case (memlen)
            LEN_BYTE: ld_data = {{24{memsign & ld_byte[7]}}, ld_byte};
            LEN_HALF: ld_data = {{16{memsign & ld_half[15]}}, ld_half};
            LEN_WORD: ld_data = ld_word;
            default:  ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage with a stall-on-access data-memory FSM.
//   clk, rst        clock, synchronous active-high reset
//   *_i             execute-side controls and data, captured when not stalled
//   dmem            data-memory bus (master side)
//   stall_o         hold upstream while an access is outstanding
//   exc_o           one-cycle misalignment pulse
//   cwd_mem, we_mem, wa_mem, wd_mem   forwarding view of the stage
//   regwe_o, wa_o, wd_o               writeback port
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | stage holds a bubble, an ALU op, or a misaligned access
//   WAIT  | aligned access outstanding on dmem; upstream stalled
//   DONE  | access acked; load data valid in ldata_r, stage accepts input
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cregwa_i,
    input  logic [1:0]  cregwd_i,
    input  logic        regwe_i,
    input  logic [1:0]  memlen_i,
    input  logic        memwe_i,
    input  logic        memsign_i,
    input  logic [31:0] rd2_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] aluout_i,
    mem_stage_if.master dmem,
    output logic        stall_o,
    output logic        exc_o,
    output logic [1:0]  cwd_mem,
    output logic        we_mem,
    output logic [4:0]  wa_mem,
    output logic [31:0] wd_mem,
    output logic        regwe_o,
    output logic [4:0]  wa_o,
    output logic [31:0] wd_o
);

    state_e      state, state_nxt;
    stage_t      stg, stg_in;
    logic [31:0] ldata_r;
    logic [31:0] ldata_ext;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        acc_r, load_r, exc, capture;
    logic [4:0]  wa_sel;
    logic [31:0] wd_sel;
    logic        regwe_wb;
    logic        req_c, we_c;
    logic [31:0] addr_c, wdata_c;
    logic [3:0]  be_c;

    assign stg_in = '{cregwa:  cregwa_i,
                      cregwd:  cregwd_i,
                      regwe:   regwe_i,
                      memlen:  memlen_i,
                      memwe:   memwe_i,
                      memsign: memsign_i,
                      rd2:     rd2_i,
                      rt:      rt_i,
                      rd:      rd_i,
                      aluout:  aluout_i};

    assign capture = (state != ST_WAIT);
    assign acc_r   = is_access(stg.memwe, stg.cregwd);
    assign load_r  = ~stg.memwe & (stg.cregwd == CWD_MEM);
    // Misaligned accesses never leave IDLE, so this lasts one captured cycle.
    assign exc     = (state == ST_IDLE) & acc_r & is_misaligned(stg.memlen, stg.aluout[1:0]);

    mem_align u_align (
        .memlen  (stg.memlen),
        .memsign (stg.memsign),
        .addr_lo (stg.aluout[1:0]),
        .st_data (stg.rd2),
        .ld_word (dmem.dmem_rdata),
        .be      (be),
        .wdata   (wdata),
        .ld_data (ldata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            stg     <= '0;
            ldata_r <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                stg <= stg_in;
            end
            if ((state == ST_WAIT) && dmem.dmem_ack) begin
                ldata_r <= ldata_ext;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: begin
                if (dmem.dmem_ack) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                // IDLE and DONE both capture this cycle; decide on the incoming op.
                if (is_access(memwe_i, cregwd_i) && !is_misaligned(memlen_i, aluout_i[1:0])) begin
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        wa_sel = stg.rt;
        case (stg.cregwa)
            CWA_RT:  wa_sel = stg.rt;
            CWA_RD:  wa_sel = stg.rd;
            default: wa_sel = stg.rt;
        endcase

        wd_sel = '0;
        case (stg.cregwd)
            CWD_ALU: wd_sel = stg.aluout;
            CWD_MEM: wd_sel = (load_r && (state == ST_DONE)) ? ldata_r : '0;
            default: wd_sel = '0;
        endcase

        regwe_wb = stg.regwe & ~exc & (acc_r ? (load_r & (state == ST_DONE)) : 1'b1);
    end

    always_comb begin
        stall_o = 1'b0;
        exc_o   = 1'b0;
        cwd_mem = '0;
        we_mem  = 1'b0;
        wa_mem  = '0;
        wd_mem  = '0;
        regwe_o = 1'b0;
        wa_o    = '0;
        wd_o    = '0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        addr_c  = '0;
        be_c    = '0;
        wdata_c = '0;
        // Outputs are masked during reset so an abandoned access drops at once.
        if (!rst) begin
            stall_o = (state == ST_WAIT);
            exc_o   = exc;
            cwd_mem = stg.cregwd;
            we_mem  = stg.regwe & ~exc;
            wa_mem  = wa_sel;
            wd_mem  = wd_sel;
            regwe_o = regwe_wb;
            wa_o    = wa_sel;
            wd_o    = wd_sel;
            if (state == ST_WAIT) begin
                req_c   = 1'b1;
                we_c    = stg.memwe;
                addr_c  = {stg.aluout[31:2], 2'b00};
                be_c    = be;
                wdata_c = stg.memwe ? wdata : '0;
            end
        end
    end

    assign dmem.dmem_req   = req_c;
    assign dmem.dmem_we    = we_c;
    assign dmem.dmem_addr  = addr_c;
    assign dmem.dmem_be    = be_c;
    assign dmem.dmem_wdata = wdata_c;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        cregwa_i;
    logic [1:0]  cregwd_i;
    logic        regwe_i;
    logic [1:0]  memlen_i;
    logic        memwe_i;
    logic        memsign_i;
    logic [31:0] rd2_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [31:0] aluout_i;
    logic        stall_o, exc_o, we_mem, regwe_o;
    logic [1:0]  cwd_mem;
    logic [4:0]  wa_mem, wa_o;
    logic [31:0] wd_mem, wd_o;

    int passed = 0;
    int total  = 0;

    mem_stage_if dmem_bus ();

    mem_stage dut (
        .clk       (clk),
        .rst       (rst),
        .cregwa_i  (cregwa_i),
        .cregwd_i  (cregwd_i),
        .regwe_i   (regwe_i),
        .memlen_i  (memlen_i),
        .memwe_i   (memwe_i),
        .memsign_i (memsign_i),
        .rd2_i     (rd2_i),
        .rt_i      (rt_i),
        .rd_i      (rd_i),
        .aluout_i  (aluout_i),
        .dmem      (dmem_bus),
        .stall_o   (stall_o),
        .exc_o     (exc_o),
        .cwd_mem   (cwd_mem),
        .we_mem    (we_mem),
        .wa_mem    (wa_mem),
        .wd_mem    (wd_mem),
        .regwe_o   (regwe_o),
        .wa_o      (wa_o),
        .wd_o      (wd_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cwa, input logic [1:0] cwd, input logic we,
                         input logic [1:0] len, input logic mwe, input logic sgn,
                         input logic [31:0] rd2, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] alu);
        cregwa_i  = cwa;
        cregwd_i  = cwd;
        regwe_i   = we;
        memlen_i  = len;
        memwe_i   = mwe;
        memsign_i = sgn;
        rd2_i     = rd2;
        rt_i      = rt;
        rd_i      = rd;
        aluout_i  = alu;
    endtask

    task automatic bubble();
        drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 5'd0, 5'd0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(CWA_RD, CWD_ALU, 1'b1, LEN_WORD, 1'b0, 1'b0, 32'h0, 5'd2, 5'd4, 32'hCAFE);
        step();
        step();
        total++; if (stall_o !== 1'b0) $display("FAIL rst_stall got %0b want 0", stall_o); else passed++;
        total++; if (regwe_o !== 1'b0) $display("FAIL rst_regwe got %0b want 0", regwe_o); else passed++;
        total++; if (wd_o !== 32'h0) $display("FAIL rst_wd got %h want 0", wd_o); else passed++;
        total++; if (wa_mem !== 5'd0) $display("FAIL rst_wa_mem got %0d want 0", wa_mem); else passed++;
        total++; if (we_mem !== 1'b0) $display("FAIL rst_we_mem got %0b want 0", we_mem); else passed++;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL rst_req got %0b want 0", dmem_bus.dmem_req); else passed++;
        total++; if (exc_o !== 1'b0) $display("FAIL rst_exc got %0b want 0", exc_o); else passed++;
        rst = 1'b0;
        bubble();
        step();
    endtask

    task automatic test_alu();
        drive(CWA_RD, CWD_ALU, 1'b1, LEN_WORD, 1'b0, 1'b0, 32'h0, 5'd7, 5'd5, 32'h1234);
        step();
        total++; if (regwe_o !== 1'b1) $display("FAIL alu_regwe got %0b want 1", regwe_o); else passed++;
        total++; if (wa_o !== 5'd5) $display("FAIL alu_wa got %0d want 5", wa_o); else passed++;
        total++; if (wd_o !== 32'h1234) $display("FAIL alu_wd got %h want 00001234", wd_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL alu_stall got %0b want 0", stall_o); else passed++;
        total++; if (wd_mem !== 32'h1234) $display("FAIL alu_wd_mem got %h want 00001234", wd_mem); else passed++;
        total++; if (we_mem !== 1'b1) $display("FAIL alu_we_mem got %0b want 1", we_mem); else passed++;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL alu_req got %0b want 0", dmem_bus.dmem_req); else passed++;
        // rt select, and a write to r0 still asserts regwe_o
        drive(CWA_RT, CWD_ALU, 1'b1, LEN_WORD, 1'b0, 1'b0, 32'h0, 5'd0, 5'd9, 32'h77);
        dmem_bus.dmem_ack = 1'b1;
        step();
        dmem_bus.dmem_ack = 1'b0;
        total++; if (wa_mem !== 5'd0) $display("FAIL alu_rt_wa got %0d want 0", wa_mem); else passed++;
        total++; if (regwe_o !== 1'b1) $display("FAIL alu_r0_regwe got %0b want 1", regwe_o); else passed++;
        total++; if (wd_o !== 32'h77) $display("FAIL alu_ack_ign_wd got %h want 00000077", wd_o); else passed++;
        bubble();
        step();
        total++; if (regwe_o !== 1'b0) $display("FAIL alu_one_cycle got %0b want 0", regwe_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL alu_ack_ign_stall got %0b want 0", stall_o); else passed++;
    endtask

    task automatic test_word_load();
        drive(CWA_RT, CWD_MEM, 1'b1, LEN_WORD, 1'b0, 1'b0, 32'h0, 5'd9, 5'd1, 32'h100);
        step();
        // upstream presents an ALU op that must wait until the load completes
        drive(CWA_RD, CWD_ALU, 1'b1, LEN_WORD, 1'b0, 1'b0, 32'h0, 5'd1, 5'd3, 32'h55);
        total++; if (dmem_bus.dmem_we !== 1'b0) $display("FAIL wl_we got %0b want 0", dmem_bus.dmem_we); else passed++;
        total++; if (dmem_bus.dmem_be !== 4'b1111) $display("FAIL wl_be got %b want 1111", dmem_bus.dmem_be); else passed++;
        for (int i = 0; i < 3; i++) begin
            total++; if (stall_o !== 1'b1) $display("FAIL wl_stall cycle %0d got %0b want 1", i, stall_o); else passed++;
            total++; if (dmem_bus.dmem_addr !== 32'h100) $display("FAIL wl_addr cycle %0d got %h want 00000100", i, dmem_bus.dmem_addr); else passed++;
            total++; if (regwe_o !== 1'b0) $display("FAIL wl_regwe_wait cycle %0d got %0b want 0", i, regwe_o); else passed++;
            if (i == 2) begin
                dmem_bus.dmem_ack   = 1'b1;
                dmem_bus.dmem_rdata = 32'hDEADBEEF;
            end
            step();
        end
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        total++; if (stall_o !== 1'b0) $display("FAIL wl_done_stall got %0b want 0", stall_o); else passed++;
        total++; if (regwe_o !== 1'b1) $display("FAIL wl_done_regwe got %0b want 1", regwe_o); else passed++;
        total++; if (wd_o !== 32'hDEADBEEF) $display("FAIL wl_done_wd got %h want deadbeef", wd_o); else passed++;
        total++; if (wa_o !== 5'd9) $display("FAIL wl_done_wa got %0d want 9", wa_o); else passed++;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL wl_done_req got %0b want 0", dmem_bus.dmem_req); else passed++;
        step();
        total++; if (wd_o !== 32'h55) $display("FAIL wl_held_alu_wd got %h want 00000055", wd_o); else passed++;
        total++; if (wa_o !== 5'd3) $display("FAIL wl_held_alu_wa got %0d want 3", wa_o); else passed++;
        bubble();
        step();
    endtask

    task automatic test_sub_word_load();
        drive(CWA_RT, CWD_MEM, 1'b1, LEN_BYTE, 1'b0, 1'b1, 32'h0, 5'd4, 5'd0, 32'h103);
        step();
        total++; if (dmem_bus.dmem_be !== 4'b1000) $display("FAIL bl_be got %b want 1000", dmem_bus.dmem_be); else passed++;
        total++; if (dmem_bus.dmem_addr !== 32'h100) $display("FAIL bl_addr got %h want 00000100", dmem_bus.dmem_addr); else passed++;
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h80000000;
        // same byte load, unsigned, captured straight out of DONE
        drive(CWA_RT, CWD_MEM, 1'b1, LEN_BYTE, 1'b0, 1'b0, 32'h0, 5'd4, 5'd0, 32'h103);
        step();
        dmem_bus.dmem_ack = 1'b0;
        total++; if (wd_o !== 32'hFFFFFF80) $display("FAIL bl_signed got %h want ffffff80", wd_o); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL bl_one_stall got %0b want 0", stall_o); else passed++;
        step();
        total++; if (stall_o !== 1'b1) $display("FAIL bl_done_to_wait got %0b want 1", stall_o); else passed++;
        dmem_bus.dmem_ack = 1'b1;
        drive(CWA_RT, CWD_MEM, 1'b1, LEN_HALF, 1'b0, 1'b1, 32'h0, 5'd6, 5'd0, 32'h102);
        step();
        dmem_bus.dmem_ack = 1'b0;
        total++; if (wd_o !== 32'h00000080) $display("FAIL bl_unsigned got %h want 00000080", wd_o); else passed++;
        step();
        total++; if (dmem_bus.dmem_be !== 4'b1100) $display("FAIL hl_be got %b want 1100", dmem_bus.dmem_be); else passed++;
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h80011234;
        bubble();
        step();
        dmem_bus.dmem_ack = 1'b0;
        total++; if (wd_o !== 32'hFFFF8001) $display("FAIL hl_signed got %h want ffff8001", wd_o); else passed++;
        total++; if (wa_o !== 5'd6) $display("FAIL hl_wa got %0d want 6", wa_o); else passed++;
        step();
        total++; if (regwe_o !== 1'b0) $display("FAIL hl_after_done_regwe got %0b want 0", regwe_o); else passed++;
    endtask

    task automatic test_store();
        logic seen_wb;
        drive(CWA_RT, CWD_ALU, 1'b1, LEN_HALF, 1'b1, 1'b0, 32'hAAAA5555, 5'd2, 5'd0, 32'h202);
        step();
        bubble();
        total++; if (dmem_bus.dmem_be !== 4'b1100) $display("FAIL hs_be got %b want 1100", dmem_bus.dmem_be); else passed++;
        total++; if (dmem_bus.dmem_wdata !== 32'h55555555) $display("FAIL hs_wdata got %h want 55555555", dmem_bus.dmem_wdata); else passed++;
        total++; if (dmem_bus.dmem_we !== 1'b1) $display("FAIL hs_we got %0b want 1", dmem_bus.dmem_we); else passed++;
        total++; if (dmem_bus.dmem_addr !== 32'h200) $display("FAIL hs_addr got %h want 00000200", dmem_bus.dmem_addr); else passed++;
        seen_wb = regwe_o;
        step();
        seen_wb = seen_wb | regwe_o;
        dmem_bus.dmem_ack = 1'b1;
        step();
        dmem_bus.dmem_ack = 1'b0;
        seen_wb = seen_wb | regwe_o;
        total++; if (stall_o !== 1'b0) $display("FAIL hs_done_stall got %0b want 0", stall_o); else passed++;
        step();
        seen_wb = seen_wb | regwe_o;
        total++; if (seen_wb !== 1'b0) $display("FAIL hs_no_regwe got %0b want 0", seen_wb); else passed++;

        drive(CWA_RT, CWD_ALU, 1'b0, LEN_BYTE, 1'b1, 1'b0, 32'h123456AB, 5'd0, 5'd0, 32'h201);
        step();
        total++; if (dmem_bus.dmem_be !== 4'b0010) $display("FAIL bs_be got %b want 0010", dmem_bus.dmem_be); else passed++;
        total++; if (dmem_bus.dmem_wdata !== 32'hABABABAB) $display("FAIL bs_wdata got %h want abababab", dmem_bus.dmem_wdata); else passed++;
        dmem_bus.dmem_ack = 1'b1;
        drive(CWA_RT, CWD_ALU, 1'b0, LEN_WORD, 1'b1, 1'b0, 32'h0BADF00D, 5'd0, 5'd0, 32'h204);
        step();
        dmem_bus.dmem_ack = 1'b0;
        step();
        total++; if (dmem_bus.dmem_be !== 4'b1111) $display("FAIL ws_be got %b want 1111", dmem_bus.dmem_be); else passed++;
        total++; if (dmem_bus.dmem_wdata !== 32'h0BADF00D) $display("FAIL ws_wdata got %h want 0badf00d", dmem_bus.dmem_wdata); else passed++;
        dmem_bus.dmem_ack = 1'b1;
        bubble();
        step();
        dmem_bus.dmem_ack = 1'b0;
        step();
    endtask

    task automatic test_misaligned();
        drive(CWA_RT, CWD_MEM, 1'b1, LEN_WORD, 1'b0, 1'b0, 32'h0, 5'd8, 5'd0, 32'h101);
        step();
        bubble();
        total++; if (exc_o !== 1'b1) $display("FAIL ma_word_exc got %0b want 1", exc_o); else passed++;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL ma_word_req got %0b want 0", dmem_bus.dmem_req); else passed++;
        total++; if (regwe_o !== 1'b0) $display("FAIL ma_word_regwe got %0b want 0", regwe_o); else passed++;
        total++; if (we_mem !== 1'b0) $display("FAIL ma_word_we_mem got %0b want 0", we_mem); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL ma_word_stall got %0b want 0", stall_o); else passed++;
        step();
        total++; if (exc_o !== 1'b0) $display("FAIL ma_exc_pulse got %0b want 0", exc_o); else passed++;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL ma_req_after got %0b want 0", dmem_bus.dmem_req); else passed++;
        drive(CWA_RT, CWD_ALU, 1'b0, LEN_HALF, 1'b1, 1'b0, 32'h1111, 5'd0, 5'd0, 32'h203);
        step();
        bubble();
        total++; if (exc_o !== 1'b1) $display("FAIL ma_half_exc got %0b want 1", exc_o); else passed++;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL ma_half_req got %0b want 0", dmem_bus.dmem_req); else passed++;
        step();
    endtask

    task automatic test_rst_in_wait();
        drive(CWA_RD, CWD_MEM, 1'b1, LEN_WORD, 1'b0, 1'b0, 32'h0, 5'd0, 5'd12, 32'h300);
        step();
        bubble();
        total++; if (dmem_bus.dmem_req !== 1'b1) $display("FAIL rw_req_before got %0b want 1", dmem_bus.dmem_req); else passed++;
        rst = 1'b1;
        #1;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL rw_req_in_rst got %0b want 0", dmem_bus.dmem_req); else passed++;
        total++; if (stall_o !== 1'b0) $display("FAIL rw_stall_in_rst got %0b want 0", stall_o); else passed++;
        total++; if (wa_mem !== 5'd0) $display("FAIL rw_wa_in_rst got %0d want 0", wa_mem); else passed++;
        step();
        rst = 1'b0;
        dmem_bus.dmem_ack   = 1'b1;
        dmem_bus.dmem_rdata = 32'h12345678;
        step();
        dmem_bus.dmem_ack = 1'b0;
        total++; if (stall_o !== 1'b0) $display("FAIL rw_late_ack_stall got %0b want 0", stall_o); else passed++;
        total++; if (regwe_o !== 1'b0) $display("FAIL rw_late_ack_regwe got %0b want 0", regwe_o); else passed++;
        total++; if (wd_o !== 32'h0) $display("FAIL rw_late_ack_wd got %h want 0", wd_o); else passed++;
        total++; if (dmem_bus.dmem_req !== 1'b0) $display("FAIL rw_late_ack_req got %0b want 0", dmem_bus.dmem_req); else passed++;
        step();
        total++; if (regwe_o !== 1'b0) $display("FAIL rw_no_wb got %0b want 0", regwe_o); else passed++;
        total++; if (wd_mem !== 32'h0) $display("FAIL rw_no_wd_mem got %h want 0", wd_mem); else passed++;
    endtask

    initial begin
        rst                 = 1'b1;
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        bubble();
        test_reset();
        test_alu();
        test_word_load();
        test_sub_word_load();
        test_store();
        test_misaligned();
        test_rst_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
